// File: rtl/issue_unit_pkg.sv
// Shared issue/scoreboard definitions: functional-unit codes, register-file
// geometry, hold-register state encoding and the held-instruction record.
package issue_unit_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int FU_W     = 2;
  localparam int NUM_FU   = 4;

  localparam logic [FU_W-1:0] FU_ALU = 2'd0;
  localparam logic [FU_W-1:0] FU_MUL = 2'd1;
  localparam logic [FU_W-1:0] FU_LSU = 2'd2;
  localparam logic [FU_W-1:0] FU_BRU = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [FU_W-1:0]   fu;
    logic              uses_rt;
    logic              writes_rd;
  } instr_t;

  // An instruction claims a scoreboard entry only if it really writes a non-zero rd.
  function automatic logic marks_rd(instr_t i);
    return i.writes_rd && (i.rd != '0);
  endfunction

endpackage

// File: rtl/issue_unit_hazard_check.sv
// Combinational RAW/WAW/structural hazard detection for the held instruction.
module hazard_check
  import issue_unit_pkg::*;
(
  input  logic [REG_AW-1:0]   rs,
  input  logic [REG_AW-1:0]   rt,
  input  logic [REG_AW-1:0]   rd,
  input  logic [FU_W-1:0]     fu,
  input  logic                uses_rt,
  input  logic                writes_rd,
  input  logic [NUM_REGS-1:0] pnd_sgn,
  input  logic [NUM_FU-1:0]   fu_busy,
  input  logic                byp_valid,
  input  logic [REG_AW-1:0]   byp_rd,
  output logic                hazard
);

  logic [NUM_REGS-1:0] pending;

  // The last marked rd is not yet visible in pnd_sgn; register 0 is never pending.
  always_comb begin
    pending = pnd_sgn;
    if (byp_valid) pending[byp_rd] = 1'b1;
    pending[0] = 1'b0;
    hazard = pending[rs]
           | (uses_rt & pending[rt])
           | (writes_rd & pending[rd])
           | fu_busy[fu];
  end

endmodule

// File: rtl/issue_unit.sv
// Single-entry in-order issue stage with scoreboard marking and stall watchdog.
// Optional ISSUE_PERF_CNT_EN adds perf_issued / perf_stalled counters.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int STALL_LIMIT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_AW-1:0]   in_rs,
  input  logic [REG_AW-1:0]   in_rt,
  input  logic [REG_AW-1:0]   in_rd,
  input  logic [FU_W-1:0]     in_fu,
  input  logic                in_uses_rt,
  input  logic                in_writes_rd,
  input  logic [NUM_REGS-1:0] pnd_sgn,
  input  logic [NUM_FU-1:0]   fu_busy,
  output logic [REG_AW-1:0]   reg_addr,
  output logic [FU_W-1:0]     func_uni,
  output logic                wre,
  output logic                iss_valid,
  output logic [REG_AW-1:0]   iss_rs,
  output logic [REG_AW-1:0]   iss_rt,
  output logic [REG_AW-1:0]   iss_rd,
  output logic [FU_W-1:0]     iss_fu,
  output logic                deadlock
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stalled
`endif
);

  localparam int CW = $clog2(STALL_LIMIT + 1);

  state_t            state, state_nxt;
  instr_t            held, in_instr;
  logic              hazard, issue, accept, stall, mark;
  logic              byp_valid;
  logic [REG_AW-1:0] byp_rd;
  logic [CW-1:0]     stall_cnt;

  assign in_instr = {in_rs, in_rt, in_rd, in_fu, in_uses_rt, in_writes_rd};

  hazard_check u_hazard (
    .rs       (held.rs),
    .rt       (held.rt),
    .rd       (held.rd),
    .fu       (held.fu),
    .uses_rt  (held.uses_rt),
    .writes_rd(held.writes_rd),
    .pnd_sgn  (pnd_sgn),
    .fu_busy  (fu_busy),
    .byp_valid(byp_valid),
    .byp_rd   (byp_rd),
    .hazard   (hazard)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_HELD;
      ST_HELD:  if (issue)  state_nxt = accept ? ST_HELD : ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    issue    = (state == ST_HELD) && !hazard;
    stall    = (state == ST_HELD) && hazard;
    in_ready = reset && ((state == ST_EMPTY) || !hazard);
    accept   = in_valid && in_ready;
    mark     = marks_rd(held);
  end

  always_ff @(posedge clock) begin
    if (accept) held <= in_instr;
  end

  // Issue boundary: execute-stage and scoreboard-mark outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      iss_valid <= 1'b0;
      wre       <= 1'b1;
      reg_addr  <= '0;
      func_uni  <= '0;
      iss_rs    <= '0;
      iss_rt    <= '0;
      iss_rd    <= '0;
      iss_fu    <= '0;
      byp_valid <= 1'b0;
      byp_rd    <= '0;
    end else begin
      iss_valid <= issue;
      wre       <= !(issue && mark);
      byp_valid <= issue && mark;
      if (issue) begin
        iss_rs <= held.rs;
        iss_rt <= held.rt;
        iss_rd <= held.rd;
        iss_fu <= held.fu;
      end
      if (issue && mark) begin
        reg_addr <= held.rd;
        func_uni <= held.fu;
        byp_rd   <= held.rd;
      end
    end
  end

  // Watchdog counter saturates at the limit; deadlock is sticky until reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= '0;
      deadlock  <= 1'b0;
    end else begin
      if (issue)
        stall_cnt <= '0;
      else if (stall && (stall_cnt != CW'(STALL_LIMIT)))
        stall_cnt <= stall_cnt + 1'b1;
      if (stall && (stall_cnt >= CW'(STALL_LIMIT - 1)))
        deadlock <= 1'b1;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_issued  <= '0;
      perf_stalled <= '0;
    end else begin
      if (issue) perf_issued  <= perf_issued + 32'd1;
      if (stall) perf_stalled <= perf_stalled + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed vector table, watchdog sequence and random
// traffic, all compared against a queue-based model of the issue rules.
module tb_issue_unit;

  localparam int LIMIT = 64;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [1:0] fu;
    logic       uses_rt;
    logic       writes_rd;
  } ins_t;

  typedef struct {
    logic        rst_n;
    logic        valid;
    ins_t        ins;
    logic [31:0] pnd;
    logic [3:0]  busy;
    logic        x_ready;
    logic        x_iss;
    logic        x_wre;
    logic [4:0]  x_addr;
  } vec_t;

  logic        clock = 1'b1;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [1:0]  in_fu = '0;
  logic        in_uses_rt = 1'b0, in_writes_rd = 1'b0;
  logic [31:0] pnd_sgn = '0;
  logic [3:0]  fu_busy = '0;
  logic [4:0]  reg_addr, iss_rs, iss_rt, iss_rd;
  logic [1:0]  func_uni, iss_fu;
  logic        wre, iss_valid, deadlock;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued, perf_stalled;
  int unsigned m_issued = 0, m_stalled = 0;
`endif

  always #5 clock = ~clock;

  issue_unit #(.STALL_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_fu(in_fu),
    .in_uses_rt(in_uses_rt), .in_writes_rd(in_writes_rd),
    .pnd_sgn(pnd_sgn), .fu_busy(fu_busy),
    .reg_addr(reg_addr), .func_uni(func_uni), .wre(wre),
    .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd),
    .iss_fu(iss_fu), .deadlock(deadlock)
`ifdef ISSUE_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_stalled(perf_stalled)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  ins_t       hq[$];
  int         last_rd = -1;
  int         stall_run = 0;
  logic       e_iss = 0, e_wre = 1, e_dl = 0;
  logic [4:0] e_addr = 0, e_rs = 0, e_rt = 0, e_rd = 0;
  logic [1:0] e_fuo = 0, e_ifu = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit blocked(ins_t h, logic [31:0] pnd, logic [3:0] busy, int lrd);
    int srcs[$];
    srcs.push_back(int'(h.rs));
    if (h.uses_rt)   srcs.push_back(int'(h.rt));
    if (h.writes_rd) srcs.push_back(int'(h.rd));
    foreach (srcs[k])
      if (srcs[k] != 0 && (pnd[srcs[k]] || srcs[k] == lrd)) return 1'b1;
    return busy[h.fu];
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst_n;  in_valid = v.valid;
    in_rs = v.ins.rs; in_rt = v.ins.rt; in_rd = v.ins.rd; in_fu = v.ins.fu;
    in_uses_rt = v.ins.uses_rt; in_writes_rd = v.ins.writes_rd;
    pnd_sgn = v.pnd; fu_busy = v.busy;
  endtask

  // One clock: check in_ready mid-cycle, advance model, check registered outputs.
  task automatic cycle(input bit tab, input vec_t v);
    bit clr, ready, issued;
    int new_last;
    clr   = (hq.size() != 0) && !blocked(hq[0], pnd_sgn, fu_busy, last_rd);
    ready = reset && (hq.size() == 0 || clr);
    @(negedge clock);
    chk("in_ready", in_ready, ready);
    if (tab) chk("tab_in_ready", in_ready, v.x_ready);
    if (!reset) begin
      hq.delete(); last_rd = -1; stall_run = 0;
      e_iss = 0; e_wre = 1; e_dl = 0; e_addr = 0; e_fuo = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_ifu = 0;
`ifdef ISSUE_PERF_CNT_EN
      m_issued = 0; m_stalled = 0;
`endif
    end else begin
      issued = clr; new_last = -1;
      e_iss = issued; e_wre = 1;
      if (issued) begin
        e_rs = hq[0].rs; e_rt = hq[0].rt; e_rd = hq[0].rd; e_ifu = hq[0].fu;
        if (hq[0].writes_rd && hq[0].rd != 0) begin
          e_wre = 0; e_addr = hq[0].rd; e_fuo = hq[0].fu; new_last = hq[0].rd;
        end
        stall_run = 0;
        void'(hq.pop_front());
`ifdef ISSUE_PERF_CNT_EN
        m_issued++;
`endif
      end else if (hq.size() != 0) begin
        stall_run++;
        if (stall_run >= LIMIT) e_dl = 1;
`ifdef ISSUE_PERF_CNT_EN
        m_stalled++;
`endif
      end
      if (ready && in_valid)
        hq.push_back({in_rs, in_rt, in_rd, in_fu, in_uses_rt, in_writes_rd});
      last_rd = new_last;
    end
    @(posedge clock); #1;
    chk("iss_valid", iss_valid, e_iss);
    chk("wre", wre, e_wre);
    chk("reg_addr", reg_addr, e_addr);
    chk("func_uni", func_uni, e_fuo);
    chk("iss_rs", iss_rs, e_rs);
    chk("iss_rt", iss_rt, e_rt);
    chk("iss_rd", iss_rd, e_rd);
    chk("iss_fu", iss_fu, e_ifu);
    chk("deadlock", deadlock, e_dl);
`ifdef ISSUE_PERF_CNT_EN
    chk("perf_issued", perf_issued, m_issued);
    chk("perf_stalled", perf_stalled, m_stalled);
`endif
    if (tab) begin
      chk("tab_iss_valid", iss_valid, v.x_iss);
      chk("tab_wre", wre, v.x_wre);
      chk("tab_reg_addr", reg_addr, v.x_addr);
    end
  endtask

  function automatic vec_t mk(logic rn, logic vl, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] rd, logic [1:0] fu, logic ur, logic wr,
                              logic [31:0] pnd, logic [3:0] busy,
                              logic xr, logic xi, logic xw, logic [4:0] xa);
    vec_t v;
    v.rst_n = rn; v.valid = vl; v.ins = {rs, rt, rd, fu, ur, wr};
    v.pnd = pnd; v.busy = busy;
    v.x_ready = xr; v.x_iss = xi; v.x_wre = xw; v.x_addr = xa;
    return v;
  endfunction

  vec_t tab[20];
  vec_t r;

  initial begin
    //            rn vl rs rt rd fu ur wr pnd           busy  rdy iss wre addr
    tab[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        4'h0, 0,  0,  1,  0);
    tab[1]  = mk(0, 1, 1, 2, 3, 0, 1, 1, 32'h0,        4'h0, 0,  0,  1,  0);
    tab[2]  = mk(1, 1, 1, 2, 3, 0, 1, 1, 32'h0,        4'h0, 1,  0,  1,  0);
    tab[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        4'h0, 1,  1,  0,  3);
    tab[4]  = mk(1, 1, 5, 0, 6, 1, 1, 1, 32'h0,        4'h0, 1,  0,  1,  3);
    tab[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h20,       4'h0, 0,  0,  1,  3);
    tab[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h20,       4'h0, 0,  0,  1,  3);
    tab[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h20,       4'h0, 0,  0,  1,  3);
    tab[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        4'h0, 1,  1,  0,  6);
    tab[9]  = mk(1, 1, 1, 0, 7, 0, 0, 1, 32'h0,        4'h0, 1,  0,  1,  6);
    tab[10] = mk(1, 1, 7, 0, 8, 1, 0, 1, 32'h0,        4'h0, 1,  1,  0,  7);
    tab[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        4'h0, 0,  0,  1,  7);
    tab[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        4'h0, 1,  1,  0,  8);
    tab[13] = mk(1, 1, 0, 0, 0, 3, 1, 1, 32'hFFFFFFFF, 4'h0, 1,  0,  1,  8);
    tab[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 4'h0, 1,  1,  1,  8);
    tab[15] = mk(1, 1, 0, 0, 9, 2, 0, 0, 32'hFFFFFFFF, 4'h0, 1,  0,  1,  8);
    tab[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 4'h0, 1,  1,  1,  8);
    tab[17] = mk(1, 1, 4, 0, 10, 0, 0, 1, 32'h10,      4'h0, 1,  0,  1,  8);
    tab[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h10,       4'h0, 0,  0,  1,  0);
    tab[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        4'h0, 1,  0,  1,  0);

    for (int i = 0; i < 20; i++) begin
      apply(tab[i]);
      cycle(1'b1, tab[i]);
    end

    // Structural stall on a permanently busy unit trips the watchdog.
    r = mk(1, 1, 0, 0, 0, 2, 0, 0, 32'h0, 4'b0100, 0, 0, 1, 0);
    apply(r); cycle(1'b0, r);
    r.valid = 0;
    apply(r);
    for (int i = 0; i < LIMIT - 1; i++) cycle(1'b0, r);
    chk("deadlock_before_limit", deadlock, 1'b0);
    cycle(1'b0, r);
    chk("deadlock_at_limit", deadlock, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, r);
    r.busy = 4'h0; apply(r); cycle(1'b0, r);
    chk("deadlock_issue_pulse", iss_valid, 1'b1);
    cycle(1'b0, r);
    chk("deadlock_sticky", deadlock, 1'b1);
    r.rst_n = 0; apply(r); cycle(1'b0, r);
    chk("deadlock_reset", deadlock, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      r.rst_n = ($urandom_range(0, 149) != 0);
      r.valid = $urandom_range(0, 3) != 0;
      r.ins.rs = 5'($urandom_range(0, 7));
      r.ins.rt = 5'($urandom_range(0, 7));
      r.ins.rd = 5'($urandom_range(0, 7));
      r.ins.fu = 2'($urandom_range(0, 3));
      r.ins.uses_rt = 1'($urandom_range(0, 1));
      r.ins.writes_rd = $urandom_range(0, 3) != 0;
      r.pnd = $urandom & $urandom & $urandom;
      r.busy = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      apply(r);
      cycle(1'b0, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
